// File: rtl/usbh_defs.sv
// Shared USB host definitions: PID constants, CRC16 constants and the
// transmit sequencer state encoding.
package usbh_defs;

    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_DATA2 = 8'h87;
    localparam logic [7:0] PID_MDATA = 8'h0F;
    localparam logic [7:0] PID_ACK   = 8'hD2;

    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    // 0x8005 bit-reversed, for the LSB-first shift register
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PID    = 3'd1,
        ST_DATA   = 3'd2,
        ST_CRC_LO = 3'd3,
        ST_CRC_HI = 3'd4
    } tx_state_e;

    // DATA0/1/2/MDATA all have PID[1:0] == 2'b11
    function automatic logic is_data_pid(input logic [7:0] pid);
        return pid[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/usbh_crc16.sv
// Combinational one-byte CRC-16/USB update (reflected, LSB first).
// Returns the raw shift-register value; the sender inverts on output.
module usbh_crc16
    import usbh_defs::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] c;

    always_comb begin
        c = crc_i ^ {8'h00, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/usbh_tx_sequencer.sv
// USB FS host transmit sequencer: PID, optional payload, CRC16 trailer.
// Optional CRC_LO bit-0 corruption under `USBH_TX_CRC_ERR_INJ_EN.
module usbh_tx_sequencer
    import usbh_defs::*;
#(
    parameter int LEN_W = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [7:0]       pid_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    input  logic             data_valid_i,
    input  logic [7:0]       data_i,
    output logic             data_accept_o,
    output logic             tx_valid_o,
    output logic [7:0]       tx_data_o,
    input  logic             tx_accept_i,
    output logic             busy_o,
    output logic             done_o,
`ifdef USBH_TX_CRC_ERR_INJ_EN
    input  logic             crc_err_inj_i,
`endif
    output logic [2:0]       state_o
);

    // Handshake: a byte moves to the PHY in any cycle where tx_valid_o and
    // tx_accept_i are both high; a payload byte is taken from the source in
    // any cycle where data_accept_o is high (DATA state only).

    tx_state_e        state_q, state_d;
    logic [7:0]       pid_q, pid_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [15:0]      crc_q, crc_d;
    logic [15:0]      crc_next;
    logic             inj_bit;
    logic             xfer;

    usbh_crc16 u_crc16 (
        .crc_i  (crc_q),
        .data_i (data_i),
        .crc_o  (crc_next)
    );

`ifdef USBH_TX_CRC_ERR_INJ_EN
    logic inj_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inj_q <= 1'b0;
        end else if (state_q == ST_IDLE && start_i) begin
            inj_q <= crc_err_inj_i;
        end
    end

    assign inj_bit = inj_q;
`else
    assign inj_bit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pid_q       <= 8'h00;
            remaining_q <= '0;
            crc_q       <= CRC16_INIT;
        end else begin
            state_q     <= state_d;
            pid_q       <= pid_d;
            remaining_q <= remaining_d;
            crc_q       <= crc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pid_d         = pid_q;
        remaining_d   = remaining_q;
        crc_d         = crc_q;
        xfer          = 1'b0;
        tx_valid_o    = 1'b0;
        tx_data_o     = 8'h00;
        data_accept_o = 1'b0;
        done_o        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    pid_d       = pid_i;
                    remaining_d = len_i;
                    crc_d       = CRC16_INIT;
                    state_d     = ST_PID;
                end
            end
            ST_PID: begin
                tx_valid_o = 1'b1;
                tx_data_o  = pid_q;
                if (tx_accept_i) begin
                    if (!is_data_pid(pid_q)) begin
                        done_o  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (remaining_q == '0) begin
                        state_d = ST_CRC_LO;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                xfer          = data_valid_i & tx_accept_i;
                tx_valid_o    = data_valid_i;
                tx_data_o     = data_i;
                data_accept_o = xfer;
                if (xfer) begin
                    crc_d       = crc_next;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_CRC_LO;
                    end
                end
            end
            ST_CRC_LO: begin
                tx_valid_o = 1'b1;
                tx_data_o  = ~crc_q[7:0] ^ {7'b0, inj_bit};
                if (tx_accept_i) begin
                    state_d = ST_CRC_HI;
                end
            end
            ST_CRC_HI: begin
                tx_valid_o = 1'b1;
                tx_data_o  = ~crc_q[15:8];
                if (tx_accept_i) begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over any accept this cycle; start reloads all context
        if (abort_i && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            done_o  = 1'b0;
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign state_o = state_q;

endmodule

// File: tb/tb_usbh_tx_sequencer.sv
// Directed bench for usbh_tx_sequencer: vector table plus hand sequences
// for backpressure, abort, start-while-busy and optional error injection.
module tb_usbh_tx_sequencer;
    import usbh_defs::*;

    localparam int LEN_W = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [7:0]       pid_i;
    logic [LEN_W-1:0] len_i;
    logic             abort_i;
    logic             data_valid_i;
    logic [7:0]       data_i;
    logic             data_accept_o;
    logic             tx_valid_o;
    logic [7:0]       tx_data_o;
    logic             tx_accept_i;
    logic             busy_o;
    logic             done_o;
    logic [2:0]       state_o;
    logic             crc_err_inj_i;

    usbh_tx_sequencer #(.LEN_W(LEN_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start_i),
        .pid_i         (pid_i),
        .len_i         (len_i),
        .abort_i       (abort_i),
        .data_valid_i  (data_valid_i),
        .data_i        (data_i),
        .data_accept_o (data_accept_o),
        .tx_valid_o    (tx_valid_o),
        .tx_data_o     (tx_data_o),
        .tx_accept_i   (tx_accept_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
`ifdef USBH_TX_CRC_ERR_INJ_EN
        .crc_err_inj_i (crc_err_inj_i),
`endif
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pay_q[$];

    typedef struct {
        logic [7:0]  pid;
        int          len;
        logic [7:0]  base;
        int          n;
        logic [95:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bit-serial reference CRC-16/USB, final value already inverted
    function automatic logic [15:0] crc_usb(input logic [7:0] d[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (d[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ d[i][b]) c = (c >> 1) ^ 16'hA001;
                else                c = c >> 1;
            end
        end
        return ~c;
    endfunction

    // Starts one packet and checks every cycle against exp_q until done or abort.
    task automatic run_packet(input string tag, input logic [7:0] pid, input int len,
                              input logic [7:0] payload[$], input logic inj,
                              input bit stalls, input int abort_at, input bit poke_start);
        int   k   = 0;
        int   pi  = 0;
        int   cyc = 0;
        int   plen;
        bit   fin = 0;
        bit   in_pay;
        logic exp_v, exp_done, exp_acc, xfer;

        plen = (pid[1:0] == 2'b11) ? len : 0;

        @(negedge clk);
        start_i       = 1'b1;
        pid_i         = pid;
        len_i         = len[LEN_W-1:0];
        crc_err_inj_i = inj;
        #1;
        check({tag, "_busy_pre"}, busy_o, 1'b0);
        check({tag, "_txv_pre"}, tx_valid_o, 1'b0);
        @(negedge clk);

        while (!fin && cyc < 3000) begin
            cyc++;
            in_pay        = (k >= 1) && (k <= plen);
            start_i       = (poke_start && cyc == 3);
            pid_i         = PID_ACK;
            len_i         = '0;
            crc_err_inj_i = ~inj;
            tx_accept_i   = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            data_valid_i  = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            abort_i       = (abort_at >= 0 && in_pay && pi == abort_at);
            if (abort_i) begin
                tx_accept_i  = 1'b1;
                data_valid_i = 1'b1;
            end
            data_i = (in_pay && data_valid_i) ? payload[pi] : 8'($urandom_range(0, 255));
            #1;

            exp_v   = in_pay ? data_valid_i : 1'b1;
            exp_acc = in_pay & data_valid_i & tx_accept_i;
            xfer    = exp_v & tx_accept_i;
            exp_done = xfer && exp_q.size() == 1 && !abort_i;

            check({tag, "_busy"}, busy_o, 1'b1);
            check({tag, "_txv"}, tx_valid_o, exp_v);
            if (exp_v) check({tag, "_txd"}, tx_data_o, exp_q[0]);
            check({tag, "_dacc"}, data_accept_o, exp_acc);
            check({tag, "_done"}, done_o, exp_done);

            if (xfer) begin
                void'(exp_q.pop_front());
                k++;
                if (in_pay) pi++;
            end
            if (abort_i || (xfer && exp_q.size() == 0)) fin = 1;
            @(negedge clk);
        end

        check({tag, "_timeout"}, fin, 1'b1);
        abort_i      = 1'b0;
        start_i      = 1'b0;
        tx_accept_i  = 1'b0;
        data_valid_i = 1'b0;
        #1;
        check({tag, "_busy_post"}, busy_o, 1'b0);
        check({tag, "_state_post"}, state_o, 3'd0);
        check({tag, "_done_post"}, done_o, 1'b0);
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] c;

        vecs[0] = '{PID_DATA0, 0, 8'h00, 3,  96'hC30000};
        vecs[1] = '{PID_DATA1, 9, 8'h31, 12, 96'h4B313233343536373839C8B4};
        vecs[2] = '{PID_ACK,   5, 8'h00, 1,  96'hD2};
        vecs[3] = '{PID_DATA2, 0, 8'h00, 3,  96'h870000};
        vecs[4] = '{PID_MDATA, 0, 8'h00, 3,  96'h0F0000};

        rst           = 1'b1;
        start_i       = 1'b0;
        pid_i         = 8'h00;
        len_i         = '0;
        abort_i       = 1'b0;
        data_valid_i  = 1'b0;
        data_i        = 8'h00;
        tx_accept_i   = 1'b0;
        crc_err_inj_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_txv", tx_valid_o, 1'b0);
        check("rst_txd", tx_data_o, 8'h00);
        check("rst_dacc", data_accept_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_state", state_o, 3'd0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            pay_q.delete();
            for (int i = 0; i < vecs[v].len; i++) pay_q.push_back(vecs[v].base + 8'(i));
            for (int j = 0; j < vecs[v].n; j++) exp_q.push_back(vecs[v].exp[8*(vecs[v].n-1-j) +: 8]);
            run_packet($sformatf("vec%0d", v), vecs[v].pid, vecs[v].len, pay_q, 1'b0, 1'b0, -1, v == 1);
        end

        // 64-byte DATA0 without and with random stalls: same expected stream
        pay_q.delete();
        for (int i = 0; i < 64; i++) pay_q.push_back(8'($urandom_range(0, 255)));
        c = crc_usb(pay_q);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(PID_DATA0);
            foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
            run_packet(r == 0 ? "rnd_nostall" : "rnd_stall", PID_DATA0, 64, pay_q, 1'b0, r == 1, -1, 1'b0);
        end

        // Abort after 3 payload bytes, then a ZLP must carry a fresh CRC
        pay_q.delete();
        for (int i = 0; i < 10; i++) pay_q.push_back(8'hA0 + 8'(i));
        c = crc_usb(pay_q);
        exp_q.push_back(PID_DATA0);
        foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        run_packet("abort", PID_DATA0, 10, pay_q, 1'b0, 1'b0, 3, 1'b0);
        pay_q.delete();
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        run_packet("zlp_after_abort", PID_DATA0, 0, pay_q, 1'b0, 1'b0, -1, 1'b0);

`ifdef USBH_TX_CRC_ERR_INJ_EN
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h00);
        run_packet("inj", PID_DATA0, 0, pay_q, 1'b1, 1'b0, -1, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
